// File: rtl/servo_pwm_multi.sv
`default_nettype none
// ============================================================================
// servo_pwm_multi : N-channel servo PWM, shared frame counter, slew-limited
//                   per-channel pulse widths with clamped duty writes.
// Revision: 1.0
// ============================================================================
module servo_pwm_multi #(
  parameter int CLK_IN     = 50_000_000,
  parameter int FREQ_SERVO = 50,
  parameter int N_CH       = 4,
  parameter int DUTY_W     = 18,
  parameter int MIN_PULSE  = 50_000,
  parameter int MAX_PULSE  = 100_000,
  parameter int STEP       = 500,
  localparam int c_CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [c_CH_W-1:0] wr_ch,
  input  logic [DUTY_W-1:0] wr_duty,
  output logic              wr_err,
  output logic              period_start,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   pwm_out
);

  localparam int c_TOTAL_PERIOD = CLK_IN / FREQ_SERVO;
  localparam int c_CNT_W        = (c_TOTAL_PERIOD > 1) ? $clog2(c_TOTAL_PERIOD) : 1;
  localparam int c_CMP_W        = (c_CNT_W > DUTY_W) ? c_CNT_W : DUTY_W;
  localparam bit c_JUMP         = (STEP == 0) || (STEP >= (1 << DUTY_W));

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_TOTAL_PERIOD - 1);
  localparam logic [DUTY_W-1:0]  c_MIN      = DUTY_W'(MIN_PULSE);
  localparam logic [DUTY_W-1:0]  c_MAX      = DUTY_W'(MAX_PULSE);
  localparam logic [DUTY_W-1:0]  c_CENTER   = DUTY_W'((MIN_PULSE + MAX_PULSE) / 2);
  localparam logic [DUTY_W:0]    c_STEP     = (DUTY_W+1)'(c_JUMP ? 0 : STEP);

  if (MIN_PULSE > MAX_PULSE || MAX_PULSE >= c_TOTAL_PERIOD) begin : g_chk_pulse
    $error("servo_pwm_multi: need MIN_PULSE <= MAX_PULSE < TOTAL_PERIOD");
  end
  if (MAX_PULSE >= (1 << DUTY_W)) begin : g_chk_width
    $error("servo_pwm_multi: MAX_PULSE does not fit in DUTY_W bits");
  end
  if (N_CH < 1) begin : g_chk_nch
    $error("servo_pwm_multi: N_CH must be at least 1");
  end

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_ps;
  logic               r_err;
  logic               w_boundary;
  logic               w_accept;
  logic               w_ch_ok;
  logic [DUTY_W-1:0]  w_clamped;
  logic [c_CMP_W-1:0] w_cnt_ext;

  assign w_boundary = enable && (r_cnt == c_CNT_LAST);
  assign wr_ready   = !w_boundary;
  assign w_accept   = wr_valid && wr_ready;
  assign w_ch_ok    = ({1'b0, wr_ch} < (c_CH_W+1)'(N_CH));
  assign w_cnt_ext  = c_CMP_W'(r_cnt);

  always_comb begin
    w_clamped = wr_duty;
    if (wr_duty < c_MIN)
      w_clamped = c_MIN;
    else if (wr_duty > c_MAX)
      w_clamped = c_MAX;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ps  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (!enable || r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
      r_ps  <= enable && (r_cnt == '0);
      r_err <= w_accept && !w_ch_ok;
    end
  end

  assign period_start = r_ps;
  assign wr_err       = r_err;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DUTY_W-1:0] r_tgt;
    logic [DUTY_W-1:0] r_act;
    logic              r_pwm;
    logic              r_busy;
    logic [DUTY_W-1:0] w_tgt_nxt;
    logic [DUTY_W-1:0] w_act_nxt;
    logic [DUTY_W:0]   w_up;
    logic [DUTY_W:0]   w_dn;
    logic              w_sel;

    assign w_sel     = w_accept && w_ch_ok && (wr_ch == c_CH_W'(i));
    assign w_tgt_nxt = w_sel ? w_clamped : r_tgt;
    assign w_up      = {1'b0, w_tgt_nxt} - {1'b0, r_act};
    assign w_dn      = {1'b0, r_act} - {1'b0, w_tgt_nxt};

    // Width only moves at the frame boundary so a running frame keeps its length.
    always_comb begin
      w_act_nxt = r_act;
      if (w_boundary) begin
        if (c_JUMP)
          w_act_nxt = w_tgt_nxt;
        else if (w_tgt_nxt >= r_act)
          w_act_nxt = (w_up <= c_STEP) ? w_tgt_nxt : DUTY_W'({1'b0, r_act} + c_STEP);
        else
          w_act_nxt = (w_dn <= c_STEP) ? w_tgt_nxt : DUTY_W'({1'b0, r_act} - c_STEP);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_tgt  <= c_CENTER;
        r_act  <= c_CENTER;
        r_pwm  <= 1'b0;
        r_busy <= 1'b0;
      end else begin
        r_tgt  <= w_tgt_nxt;
        r_act  <= w_act_nxt;
        r_pwm  <= enable && (w_cnt_ext < c_CMP_W'(r_act));
        r_busy <= (w_act_nxt != w_tgt_nxt);
      end
    end

    assign pwm_out[i] = r_pwm;
    assign busy[i]    = r_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_multi.sv
`default_nettype none
// ============================================================================
// tb_servo_pwm_multi : random + directed bench for two servo_pwm_multi builds
//                      (N_CH=4/STEP=2 and N_CH=3/STEP=0) against a frame model.
// Revision: 1.0
// ============================================================================
module tb_servo_pwm_multi;

  localparam int c_TP     = 100;
  localparam int c_MINP   = 10;
  localparam int c_MAXP   = 20;
  localparam int c_CENTER = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_duty = '0;

  logic       a_ready, a_err, a_ps;
  logic [3:0] a_busy, a_pwm;
  logic       b_ready, b_err, b_ps;
  logic [2:0] b_busy, b_pwm;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .CLK_IN(1000), .FREQ_SERVO(10), .N_CH(4), .DUTY_W(8),
    .MIN_PULSE(c_MINP), .MAX_PULSE(c_MAXP), .STEP(2)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(a_ready), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .wr_err(a_err), .period_start(a_ps), .busy(a_busy), .pwm_out(a_pwm)
  );

  servo_pwm_multi #(
    .CLK_IN(1000), .FREQ_SERVO(10), .N_CH(3), .DUTY_W(8),
    .MIN_PULSE(c_MINP), .MAX_PULSE(c_MAXP), .STEP(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(b_ready), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .wr_err(b_err), .period_start(b_ps), .busy(b_busy), .pwm_out(b_pwm)
  );

  int n_checks = 0;
  int n_errors = 0;

  int   m_nch [2] = '{4, 3};
  int   m_step[2] = '{2, 0};
  int   m_cnt;
  int   m_tgt [2][4];
  int   m_act [2][4];
  logic [3:0] e_pwm [2];
  logic [3:0] e_busy[2];
  logic       e_err [2];
  logic       e_ps;
  bit         m_live = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampv(input int v);
    return (v < c_MINP) ? c_MINP : ((v > c_MAXP) ? c_MAXP : v);
  endfunction

  // Reference: inputs and state just before a rising edge give the state after it.
  task automatic model_edge();
    bit boundary;
    bit acc;
    int d;
    if (!rst_n) begin
      m_cnt = 0;
      e_ps  = 1'b0;
      for (int k = 0; k < 2; k++) begin
        e_pwm[k] = '0; e_busy[k] = '0; e_err[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          m_tgt[k][i] = c_CENTER;
          m_act[k][i] = c_CENTER;
        end
      end
      m_live = 1'b1;
      return;
    end
    boundary = enable && (m_cnt == c_TP - 1);
    acc      = wr_valid && !boundary;
    e_ps     = enable && (m_cnt == 0);
    for (int k = 0; k < 2; k++) begin
      e_pwm[k] = '0;
      for (int i = 0; i < m_nch[k]; i++)
        e_pwm[k][i] = enable && (m_cnt < m_act[k][i]);
      e_err[k] = 1'b0;
      if (acc) begin
        if (int'(wr_ch) < m_nch[k]) m_tgt[k][wr_ch] = clampv(int'(wr_duty));
        else                        e_err[k] = 1'b1;
      end
      if (boundary) begin
        for (int i = 0; i < m_nch[k]; i++) begin
          d = m_tgt[k][i] - m_act[k][i];
          if (m_step[k] == 0 || (d <= m_step[k] && -d <= m_step[k]))
            m_act[k][i] = m_tgt[k][i];
          else
            m_act[k][i] += (d > 0) ? m_step[k] : -m_step[k];
        end
      end
      e_busy[k] = '0;
      for (int i = 0; i < m_nch[k]; i++)
        e_busy[k][i] = (m_act[k][i] != m_tgt[k][i]);
    end
    m_cnt = enable ? (m_cnt + 1) % c_TP : 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (m_live) begin
      chk("pwm_a",   {28'd0, a_pwm},  {28'd0, e_pwm[0]});
      chk("pwm_b",   {29'd0, b_pwm},  {29'd0, e_pwm[1][2:0]});
      chk("ps_a",    {31'd0, a_ps},   {31'd0, e_ps});
      chk("ps_b",    {31'd0, b_ps},   {31'd0, e_ps});
      chk("busy_a",  {28'd0, a_busy}, {28'd0, e_busy[0]});
      chk("busy_b",  {29'd0, b_busy}, {29'd0, e_busy[1][2:0]});
      chk("err_a",   {31'd0, a_err},  {31'd0, e_err[0]});
      chk("err_b",   {31'd0, b_err},  {31'd0, e_err[1]});
      chk("ready_a", {31'd0, a_ready}, {31'd0, !(enable && m_cnt == c_TP - 1)});
      chk("ready_b", {31'd0, b_ready}, {31'd0, !(enable && m_cnt == c_TP - 1)});
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_cnt(input int c);
    int guard = 0;
    while (m_cnt != c && guard < 300) begin
      cycle();
      guard++;
    end
    if (guard >= 300) chk("wait_cnt_timeout", m_cnt, c);
  endtask

  task automatic write1(input logic [1:0] ch, input logic [7:0] duty);
    wr_valid = 1'b1; wr_ch = ch; wr_duty = duty;
    cycle();
    wr_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1; enable = 1'b1;
    run(250);

    wait_cnt(40);
    write1(2'd0, 8'd19);
    run(350);

    write1(2'd1, 8'd3);
    run(200);
    write1(2'd1, 8'd200);
    run(200);

    wait_cnt(99);
    chk("ready_low_at_99", {31'd0, a_ready}, 32'd0);
    wr_valid = 1'b1; wr_ch = 2'd2; wr_duty = 8'd11;
    cycle();
    cycle();
    wr_valid = 1'b0;
    run(300);

    write1(2'd3, 8'd12);
    run(5);

    wait_cnt(5);
    enable = 1'b0;
    run(20);
    enable = 1'b1;
    run(150);

    wait_cnt(50);
    rst_n = 1'b0;
    cycle();
    chk("rst_pwm_a", {28'd0, a_pwm}, 32'd0);
    rst_n = 1'b1;
    run(120);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 49) == 0) enable = 1'b1;
      rst_n    = ($urandom_range(0, 999) != 0);
      wr_valid = ($urandom_range(0, 7) == 0);
      wr_ch    = 2'($urandom_range(0, 3));
      wr_duty  = 8'($urandom_range(0, 255));
      cycle();
    end
    wr_valid = 1'b0;
    rst_n = 1'b1;
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
